// File: rtl/speed_gate_ctrl_if.sv
// Handshake bundle for speed_gate_ctrl: run control and pulse input in,
// window count, BCD digits and status strobes out.
interface speed_gate_ctrl_if;
    logic        enable;
    logic        signal;
    logic [13:0] count1;
    logic [3:0]  AX;
    logic [3:0]  BX;
    logic [3:0]  CX;
    logic [3:0]  DX;
    logic        valid;
    logic        stalled;
    logic        busy;

    modport master (
        output enable, signal,
        input  count1, AX, BX, CX, DX, valid, stalled, busy
    );

    modport slave (
        input  enable, signal,
        output count1, AX, BX, CX, DX, valid, stalled, busy
    );
endinterface

// File: rtl/speed_gate_ctrl.sv
// Gated pulse counter: counts encoder edges over back-to-back windows, scales
// the count, converts it to BCD with a 14-step shift-add-3 and flags stalls.
module speed_gate_ctrl #(
    parameter int GATE_CYCLES   = 50000000,
    parameter int SCALE         = 176,
    parameter int STALL_WINDOWS = 4
) (
    input logic              clk,
    input logic              rst,
    speed_gate_ctrl_if.slave bus
);
    localparam int            TW      = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] LAST    = TW'(GATE_CYCLES - 1);
    localparam logic [13:0]   CNT_MAX = 14'h3fff;

    typedef enum logic [1:0] {IDLE, GATE, CONV} state_t;

    state_t state_q, state_d;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [13:0]   count1_q, count1_d;
    logic [3:0]    stall_q, stall_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [13:0]   bin_q, bin_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   dig_q, dig_d;
    logic          valid_q, valid_d;
    logic          busy;

    logic          edge_det, win_end, stalled;
    logic [13:0]   snap, sat;
    logic [21:0]   prod;
    logic [15:0]   adj, bcd_sh;
    logic [13:0]   bin_sh;

    assign edge_det = sync2_q & ~prev_q;
    assign win_end  = (state_q != IDLE) && (timer_q == LAST);
    assign snap     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {13'd0, edge_det};
    assign prod     = {8'd0, snap} * 22'(SCALE);
    assign sat      = (prod > 22'd9999) ? 14'd9999 : prod[13:0];
    assign stalled  = (stall_q >= 4'(STALL_WINDOWS));

    // One shift-add-3 step: correct every digit >= 5, then shift left by one.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_sh, bin_sh} = {adj[14:0], bin_q, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.enable) state_d = GATE;
            GATE: begin
                if (!bus.enable)  state_d = IDLE;
                else if (win_end) state_d = CONV;
            end
            CONV: begin
                if (!bus.enable)          state_d = IDLE;
                else if (win_end)         state_d = CONV;
                else if (step_q == 4'd1)  state_d = GATE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONV);
    end

    always_comb begin
        sync1_d  = bus.signal;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        count1_d = count1_q;
        stall_d  = stall_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        step_d   = step_q;
        dig_d    = dig_q;
        valid_d  = 1'b0;
        // Disabling wins over everything: drop the window and any conversion.
        if (state_q == IDLE || !bus.enable) begin
            timer_d = '0;
            cnt_d   = '0;
            step_d  = '0;
        end else if (win_end) begin
            timer_d  = '0;
            cnt_d    = '0;
            count1_d = snap;
            bcd_d    = '0;
            bin_d    = sat;
            step_d   = 4'd14;
            if (snap != 14'd0) stall_d = '0;
            else if (stall_q != 4'hf) stall_d = stall_q + 4'd1;
        end else begin
            timer_d = timer_q + TW'(1);
            cnt_d   = snap;
            if (state_q == CONV) begin
                bcd_d  = bcd_sh;
                bin_d  = bin_sh;
                step_d = step_q - 4'd1;
                if (step_q == 4'd1) begin
                    dig_d   = stalled ? 16'd0 : bcd_sh;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            timer_q  <= '0;
            cnt_q    <= '0;
            count1_q <= '0;
            stall_q  <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            step_q   <= '0;
            dig_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            count1_q <= count1_d;
            stall_q  <= stall_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            step_q   <= step_d;
            dig_q    <= dig_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.count1  = count1_q;
    assign bus.AX      = dig_q[15:12];
    assign bus.BX      = dig_q[11:8];
    assign bus.CX      = dig_q[7:4];
    assign bus.DX      = dig_q[3:0];
    assign bus.valid   = valid_q;
    assign bus.stalled = stalled;
    assign bus.busy    = busy;
endmodule
